dvs_event_assembler: RTL and testbench

DVS_EVENT_ASSEMBLER -- requirements
Module: dvs_event_assembler

---
 rtl/dvs_ravens_pkg.sv | 30 +++
 rtl/dvs_event_fifo.sv | 62 ++++++
 rtl/dvs_event_assembler.sv | 108 ++++++++++
 tb/tb_dvs_event_assembler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared types and defaults for the DVS AER event assembler.
// Latency: n/a (types/constants only).
// Backpressure: n/a.
// Contents: default depth / timestamp width, FSM state enum, default-width
//           event record, saturating 16-bit increment helper.
package dvs_ravens_pkg;

  localparam int DVS_FIFO_DEPTH = 8;
  localparam int DVS_TS_WIDTH   = 16;

  // Row-latch state of the AER word pairing FSM.
  typedef enum logic {
    NO_ROW    = 1'b0,
    ROW_VALID = 1'b1
  } dvs_state_t;

  // Event record at the default timestamp width; also the FIFO's default
  // entry type.
  typedef struct packed {
    logic [9:0]              y;
    logic [8:0]              x;
    logic                    pol;
    logic [DVS_TS_WIDTH-1:0] ts;
  } dvs_event_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// First-word-fall-through event FIFO with registered storage.
// Latency: a push into an empty FIFO is visible at head the next cycle.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk, rst (async active-high), push/push_data, pop, head, full, empty,
//        level (0..DEPTH).
module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int  DEPTH   = DVS_FIFO_DEPTH,
  parameter type entry_t = dvs_event_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle;
  // the write lands on the slot being vacated.
  assign push_ok = push && (!full || pop_ok);

  // Head is masked while empty so the outputs read zero after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dvs_event_assembler.sv
// Pairs AER row/column words into timestamped events and buffers them.
// Latency: column pulse -> ev_valid one cycle later when the FIFO is empty.
// Backpressure: ev_valid/ev_ready; events arriving to a full FIFO are dropped
//               and counted (overflow sticky, drop_count saturating).
// Ports: clk, rst (async active-high); rx_valid/aer_rx/xsel_rx input words;
//        ev_valid/ev_ready/ev_y/ev_x/ev_pol/ev_ts output events;
//        fifo_level, overflow, drop_count, orphan_count status.
module dvs_event_assembler
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH = DVS_FIFO_DEPTH,
  parameter int TS_WIDTH   = DVS_TS_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [9:0]                  aer_rx,
  input  logic                        xsel_rx,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [9:0]                  ev_y,
  output logic [8:0]                  ev_x,
  output logic                        ev_pol,
  output logic [TS_WIDTH-1:0]         ev_ts,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  output logic [15:0]                 orphan_count
);

  // Same layout as dvs_event_t, sized to this instance's timestamp width.
  typedef struct packed {
    logic [9:0]          y;
    logic [8:0]          x;
    logic                pol;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  dvs_state_t          state;
  logic [9:0]          row_y;
  logic [TS_WIDTH-1:0] ts_counter;
  entry_t              push_ev;
  entry_t              head_ev;
  logic                push_req;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;

  assign push_req = rx_valid && xsel_rx && (state == ROW_VALID);
  assign pop      = ev_valid && ev_ready;
  assign drop     = push_req && fifo_full && !pop;

  // Column word carries x in [9:1] and polarity in [0]; the timestamp is the
  // counter value in the cycle the column word arrives.
  assign push_ev = '{y: row_y, x: aer_rx[9:1], pol: aer_rx[0], ts: ts_counter};

  dvs_event_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_ev),
    .pop       (pop),
    .head      (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ev_valid = !fifo_empty;
  assign ev_y     = head_ev.y;
  assign ev_x     = head_ev.x;
  assign ev_pol   = head_ev.pol;
  assign ev_ts    = head_ev.ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NO_ROW;
      row_y        <= '0;
      ts_counter   <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      orphan_count <= '0;
    end else begin
      ts_counter <= ts_counter + TS_WIDTH'(1);

      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end

      // Row words always (re)latch y; column words either form an event
      // (handled through push_req) or are orphans when no row is held.
      if (rx_valid) begin
        if (!xsel_rx) begin
          row_y <= aer_rx;
          state <= ROW_VALID;
        end else if (state == NO_ROW) begin
          orphan_count <= sat_inc16(orphan_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_dvs_event_assembler.sv
// Self-checking bench for dvs_event_assembler (default parameters).
// Reference model: event queue plus row/counter bookkeeping updated per cycle.
module tb_dvs_event_assembler;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [9:0]  aer_rx = '0;
  logic        xsel_rx = 1'b0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [9:0]  ev_y;
  logic [8:0]  ev_x;
  logic        ev_pol;
  logic [15:0] ev_ts;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] orphan_count;

  always #5 clk = ~clk;

  dvs_event_assembler #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .aer_rx       (aer_rx),
    .xsel_rx      (xsel_rx),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_y         (ev_y),
    .ev_x         (ev_x),
    .ev_pol       (ev_pol),
    .ev_ts        (ev_ts),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .orphan_count (orphan_count)
  );

  typedef struct {
    logic [9:0]  y;
    logic [8:0]  x;
    logic        pol;
    logic [15:0] ts;
  } mev_t;

  mev_t       mq[$];
  bit         m_has_row;
  logic [9:0] m_row;
  int         m_ts;
  int         m_drop;
  int         m_orph;
  bit         m_ovf;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic model_reset();
    mq.delete();
    m_has_row = 0;
    m_row = '0;
    m_ts = 0;
    m_drop = 0;
    m_orph = 0;
    m_ovf = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    aer_rx = '0;
    xsel_rx = 1'b0;
    ev_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; model applies the cycle's pop, push and word rules.
  task automatic cycle(input logic rv, input logic [9:0] aer, input logic xs, input logic rdy);
    mev_t e;
    rx_valid = rv;
    aer_rx = aer;
    xsel_rx = xs;
    ev_ready = rdy;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (rv && xs) begin
      if (m_has_row) begin
        if (mq.size() < DEPTH) begin
          e.y = m_row;
          e.x = aer[9:1];
          e.pol = aer[0];
          e.ts = 16'(m_ts % 65536);
          mq.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end else if (m_orph < 65535) begin
        m_orph++;
      end
    end else if (rv) begin
      m_has_row = 1;
      m_row = aer;
    end
    @(posedge clk);
    #1;
    m_ts++;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b1;
    aer_rx = 10'h3FF;
    xsel_rx = 1'b0;
    ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL rst_ev_valid: got %0h expected 0", ev_valid); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d expected 0", fifo_level); else n_pass++;
    n_checks++; if ({ev_y, ev_x, ev_pol, ev_ts} !== 36'd0) $display("FAIL rst_ev_fields: got %0h expected 0", {ev_y, ev_x, ev_pol, ev_ts}); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %0h expected 0", overflow); else n_pass++;
    n_checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop: got %0d expected 0", drop_count); else n_pass++;
    n_checks++; if (orphan_count !== 16'd0) $display("FAIL rst_orphan: got %0d expected 0", orphan_count); else n_pass++;
    do_reset();
    cycle(1'b0, 10'h0, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL post_rst_idle: got %0h expected 0", ev_valid); else n_pass++;
  endtask

  task automatic test_basic_event();
    do_reset();
    cycle(1'b1, 10'h025, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL basic_row_only: got %0h expected 0", ev_valid); else n_pass++;
    cycle(1'b1, 10'h0C9, 1'b1, 1'b0);
    n_checks++; if (ev_valid !== 1'b1) $display("FAIL basic_valid: got %0h expected 1", ev_valid); else n_pass++;
    n_checks++; if (ev_y !== 10'h025) $display("FAIL basic_y: got %0h expected 25", ev_y); else n_pass++;
    n_checks++; if (ev_x !== 9'h064) $display("FAIL basic_x: got %0h expected 64", ev_x); else n_pass++;
    n_checks++; if (ev_pol !== 1'b1) $display("FAIL basic_pol: got %0h expected 1", ev_pol); else n_pass++;
    // Row cycle sees ts 0, column cycle ts 1.
    n_checks++; if (ev_ts !== 16'd1) $display("FAIL basic_ts: got %0d expected 1", ev_ts); else n_pass++;
    cycle(1'b0, 10'h0, 1'b0, 1'b1);
    n_checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL basic_pop: got valid %0h level %0d expected 0/0", ev_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_orphan();
    do_reset();
    cycle(1'b1, 10'h010, 1'b1, 1'b0);
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL orphan_no_event: got %0h expected 0", ev_valid); else n_pass++;
    n_checks++; if (orphan_count !== 16'd1) $display("FAIL orphan_count1: got %0d expected 1", orphan_count); else n_pass++;
    cycle(1'b1, 10'h011, 1'b1, 1'b0);
    n_checks++; if (orphan_count !== 16'd2 || ev_valid !== 1'b0) $display("FAIL orphan_still_no_row: got cnt %0d valid %0h expected 2/0", orphan_count, ev_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1'b1, 10'd5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", fifo_level); else n_pass++;
    n_checks++; if (drop_count !== 16'd1) $display("FAIL ovf_drop: got %0d expected 1", drop_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0h expected 1", overflow); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_y !== 10'd5 || ev_x !== mq[0].x || ev_pol !== mq[0].pol || ev_ts !== mq[0].ts)
        $display("FAIL ovf_drain[%0d]: got v%0h y%0h x%0h p%0h t%0h expected v1 y5 x%0h p%0h t%0h",
                 i, ev_valid, ev_y, ev_x, ev_pol, ev_ts, mq[0].x, mq[0].pol, mq[0].ts);
      else n_pass++;
      cycle(1'b0, 10'h0, 1'b0, 1'b1);
    end
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL ovf_drained: got %0h expected 0", ev_valid); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    cycle(1'b1, 10'h1A5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 10'(i * 37 + 3), 1'b1, 1'b0);
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_level: got %0d expected 8", fifo_level); else n_pass++;
    cycle(1'b1, 10'h2F1, 1'b1, 1'b1);
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL fullpp_level: got %0d expected 8", fifo_level); else n_pass++;
    n_checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) $display("FAIL fullpp_drop: got %0d/%0h expected 0/0", drop_count, overflow); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_y !== mq[0].y || ev_x !== mq[0].x || ev_pol !== mq[0].pol || ev_ts !== mq[0].ts)
        $display("FAIL fullpp_drain[%0d]: got y%0h x%0h p%0h t%0h expected y%0h x%0h p%0h t%0h",
                 i, ev_y, ev_x, ev_pol, ev_ts, mq[0].y, mq[0].x, mq[0].pol, mq[0].ts);
      else n_pass++;
      cycle(1'b0, 10'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      n_checks++; if (ev_valid !== (mq.size() > 0)) $display("FAIL rnd_valid@%0d: got %0h expected %0h", n, ev_valid, mq.size() > 0); else n_pass++;
      n_checks++; if (fifo_level !== 4'(mq.size())) $display("FAIL rnd_level@%0d: got %0d expected %0d", n, fifo_level, mq.size()); else n_pass++;
      if (mq.size() > 0) begin
        n_checks++;
        if (ev_y !== mq[0].y || ev_x !== mq[0].x || ev_pol !== mq[0].pol || ev_ts !== mq[0].ts)
          $display("FAIL rnd_head@%0d: got y%0h x%0h p%0h t%0h expected y%0h x%0h p%0h t%0h",
                   n, ev_y, ev_x, ev_pol, ev_ts, mq[0].y, mq[0].x, mq[0].pol, mq[0].ts);
        else n_pass++;
      end
      n_checks++; if (drop_count !== 16'(m_drop) || overflow !== m_ovf) $display("FAIL rnd_drop@%0d: got %0d/%0h expected %0d/%0h", n, drop_count, overflow, m_drop, m_ovf); else n_pass++;
      n_checks++; if (orphan_count !== 16'(m_orph)) $display("FAIL rnd_orphan@%0d: got %0d expected %0d", n, orphan_count, m_orph); else n_pass++;
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    for (int n = 0; n < 65536; n++) cycle(1'b0, 10'h0, 1'b0, 1'b0);
    cycle(1'b1, 10'h155, 1'b0, 1'b0);
    cycle(1'b1, 10'h0AA, 1'b1, 1'b0);
    // Column arrives 65537 cycles after reset release -> wrapped value 1.
    n_checks++; if (ev_ts !== 16'd1) $display("FAIL wrap_ts: got %0d expected 1", ev_ts); else n_pass++;
    n_checks++; if (ev_valid !== 1'b1 || ev_y !== 10'h155 || ev_x !== 9'h055 || ev_pol !== 1'b0) $display("FAIL wrap_event: got v%0h y%0h x%0h p%0h expected v1 y155 x55 p0", ev_valid, ev_y, ev_x, ev_pol); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL wrap_overflow: got %0h expected 0", overflow); else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    cycle(1'b1, 10'h077, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 10'(100 + i), 1'b1, 1'b0);
    n_checks++; if (fifo_level !== 4'd3) $display("FAIL midrst_pre_level: got %0d expected 3", fifo_level); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL midrst_valid: got %0h expected 0", ev_valid); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL midrst_level: got %0d expected 0", fifo_level); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 10'h033, 1'b1, 1'b0);
    n_checks++; if (orphan_count !== 16'd1 || ev_valid !== 1'b0) $display("FAIL midrst_orphan: got cnt %0d valid %0h expected 1/0", orphan_count, ev_valid); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_event();
    test_orphan();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_ts_wrap();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
